// File: rtl/mbledhesi_sekuencial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered carry.
// Define MBLEDHESI_OVF_EN to add the registered signed-overflow output ovf.

module mbledhesi_sekuencial #(
    parameter int WIDTH = 48,
    parameter int CHUNK = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] shuma,
    output logic             carryout
`ifdef MBLEDHESI_OVF_EN
    ,
    output logic             ovf
`endif
);

    // state | meaning
    // IDLE  | waiting for start, ready high
    // RUN   | one slice per edge, start ignored
    // FUND  | result valid for one cycle, done and ready high

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FUND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] part_next;
    logic [KW-1:0]    k;
    logic             c;
    logic [CHUNK:0]   slice_sum;
    logic             accept;
    logic             last;

    assign last = (k == K_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b1;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                ready = 1'b0;
                if (last) begin
                    state_next = FUND;
                end
            end
            FUND: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One ripple slice; the finished slice is merged into the partial result.
    always_comb begin
        slice_sum = {1'b0, a_reg[k*CHUNK +: CHUNK]}
                  + {1'b0, b_eff[k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, c};
        part_next = part;
        part_next[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_eff    <= '0;
            part     <= '0;
            k        <= '0;
            c        <= 1'b0;
            shuma    <= '0;
            carryout <= 1'b0;
`ifdef MBLEDHESI_OVF_EN
            ovf      <= 1'b0;
`endif
        end else if (accept) begin
            a_reg <= a;
            b_eff <= sub ? ~b : b;
            c     <= cin ^ sub;
            k     <= '0;
        end else if (state == RUN) begin
            part <= part_next;
            c    <= slice_sum[CHUNK];
            if (last) begin
                k        <= '0;
                shuma    <= part_next;
                carryout <= slice_sum[CHUNK];
`ifdef MBLEDHESI_OVF_EN
                ovf      <= (a_reg[WIDTH-1] == b_eff[WIDTH-1]) &&
                            (part_next[WIDTH-1] != a_reg[WIDTH-1]);
`endif
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mbledhesi_sekuencial.sv
// Scoreboard bench: a 2-slice (CHUNK=24) and a 6-slice (CHUNK=8) instance against an arithmetic model.
module tb_mbledhesi_sekuencial;

    localparam int W = 48;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    int           sel = 0;

    logic         start0, start1;
    logic         ready0, done0, carry0, ovf0;
    logic         ready1, done1, carry1, ovf1;
    logic [W-1:0] shuma0, shuma1;

    assign start0 = start && (sel == 0);
    assign start1 = start && (sel == 1);

`ifndef MBLEDHESI_OVF_EN
    assign ovf0 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    mbledhesi_sekuencial #(.WIDTH(W), .CHUNK(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready0), .done(done0), .shuma(shuma0), .carryout(carry0)
`ifdef MBLEDHESI_OVF_EN
        , .ovf(ovf0)
`endif
    );

    mbledhesi_sekuencial #(.WIDTH(W), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready1), .done(done1), .shuma(shuma1), .carryout(carry1)
`ifdef MBLEDHESI_OVF_EN
        , .ovf(ovf1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int           cyc;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    int           t0[2]     = '{-1000, -1000};
    int           nch[2]    = '{2, 6};
    logic [W-1:0] last_s[2] = '{default: '0};
    logic         last_c[2] = '{default: 1'b0};
    logic         last_o[2] = '{default: 1'b0};
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
        end
    endtask

    // Busy exactly for the nch cycles after an accept edge.
    function automatic bit ready_m(input int s);
        return !(cyc >= t0[s] && cyc < t0[s] + nch[s]);
    endfunction

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic su, input logic ci);
        longint ua, ub, sa, sb, r, sr, lc;
        exp_t   e;
        ua = longint'({16'h0, aa});
        ub = longint'({16'h0, bb});
        sa = longint'({{16{aa[W-1]}}, aa});
        sb = longint'({{16{bb[W-1]}}, bb});
        lc = longint'({63'b0, ci});
        if (!su) begin
            r   = ua + ub + lc;
            sr  = sa + sb + lc;
            e.c = r[W];
        end else begin
            r   = ua - ub - lc;
            sr  = sa - sb - lc;
            e.c = (ua >= ub + lc);
        end
        e.s   = r[W-1:0];
        e.o   = (sr > 64'sh0000_7FFF_FFFF_FFFF) || (sr < -64'sh0000_8000_0000_0000);
        e.cyc = 0;
        return e;
    endfunction

    task automatic mon(input int s, input logic rdy, input logic dn,
                       input logic [W-1:0] sm, input logic co, input logic ov);
        exp_t  e;
        int    qn;
        string p;
        p = (s == 0) ? "d24" : "d8";
        if (!rst_n) begin
            chk($sformatf("%s_rst_ready", p), 64'(rdy), 64'(1));
            chk($sformatf("%s_rst_done", p), 64'(dn), 64'(0));
            chk($sformatf("%s_rst_shuma", p), 64'(sm), 64'(0));
            chk($sformatf("%s_rst_carry", p), 64'(co), 64'(0));
`ifdef MBLEDHESI_OVF_EN
            chk($sformatf("%s_rst_ovf", p), 64'(ov), 64'(0));
`endif
            return;
        end
        chk($sformatf("%s_ready", p), 64'(rdy), 64'(ready_m(s)));
        qn = (s == 0) ? q0.size() : q1.size();
        if (dn) begin
            if (qn == 0) begin
                chk($sformatf("%s_unexpected_done", p), 64'(dn), 64'(0));
            end else begin
                if (s == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("%s_done_cycle", p), 64'(cyc), 64'(e.cyc));
                last_s[s] = e.s;
                last_c[s] = e.c;
                last_o[s] = e.o;
            end
        end else if (qn > 0) begin
            if (s == 0) e = q0[0];
            else        e = q1[0];
            if (e.cyc <= cyc) begin
                chk($sformatf("%s_missing_done", p), 64'(dn), 64'(1));
                if (s == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                last_s[s] = e.s;
                last_c[s] = e.c;
                last_o[s] = e.o;
            end
        end
        chk($sformatf("%s_shuma", p), 64'(sm), 64'(last_s[s]));
        chk($sformatf("%s_carry", p), 64'(co), 64'(last_c[s]));
`ifdef MBLEDHESI_OVF_EN
        chk($sformatf("%s_ovf", p), 64'(ov), 64'(last_o[s]));
`else
        if (ov !== 1'b0) chk($sformatf("%s_ovf_tie", p), 64'(ov), 64'(last_o[s] & 1'b0));
`endif
    endtask

    always @(negedge clk) begin
        mon(0, ready0, done0, shuma0, carry0, ovf0);
        mon(1, ready1, done1, shuma1, carry1, ovf1);
    end

    function automatic logic [W-1:0] rnd48();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 48'h7FFF_FFFF_FFFF;
            3:       v = 48'h8000_0000_0000;
            4:       v = 48'h0000_00FF_FFFF;
            default: v = W'({$urandom(), $urandom()});
        endcase
        return v;
    endfunction

    // Entered and left at posedge+1; the accept edge is the first posedge after ready.
    task automatic issue(input int s, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic su, input logic ci, input bit hold);
        exp_t e;
        int   n;
        n     = 0;
        sel   = s;
        a     = aa;
        b     = bb;
        sub   = su;
        cin   = ci;
        start = 1'b1;
        while (!ready_m(s) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!ready_m(s)) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: dut %0d still busy after %0d cycles", s, n);
            start = 1'b0;
            return;
        end
        e     = model(aa, bb, su, ci);
        e.cyc = cyc + 1 + nch[s];
        t0[s] = cyc + 1;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            t0[i]     = -1000;
            last_s[i] = '0;
            last_c[i] = 1'b0;
            last_o[i] = 1'b0;
        end
        repeat (n) begin
            start = 1'b1;
            sel   = int'($urandom_range(0, 1));
            a     = rnd48();
            b     = rnd48();
            sub   = 1'($urandom());
            cin   = 1'($urandom());
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        do_reset(4);
        idle(3);

        issue(0, 48'h0000_00FF_FFFF, 48'd1, 1'b0, 1'b0, 1'b0);
        issue(0, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b1, 1'b0);
        issue(0, 48'd5, 48'd7, 1'b1, 1'b0, 1'b0);
        issue(0, 48'h7FFF_FFFF_FFFF, 48'd1, 1'b0, 1'b0, 1'b0);
        issue(0, 48'd3, 48'd1, 1'b1, 1'b0, 1'b0);
        idle(4);

        for (int i = 0; i < 40; i++) begin
            bit hold;
            hold = ($urandom_range(0, 2) == 0);
            issue(0, rnd48(), rnd48(), 1'($urandom()), 1'($urandom()), hold);
            if (!hold && $urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
        end
        idle(6);

        for (int i = 0; i < 4; i++) begin
            issue(1, rnd48(), rnd48(), 1'($urandom()), 1'($urandom()), 1'b1);
        end
        idle(10);

        issue(1, 48'h0000_00FF_FFFF, 48'd1, 1'b0, 1'b0, 1'b0);
        repeat (4) begin
            start = 1'b1;
            a     = rnd48();
            b     = rnd48();
            sub   = 1'($urandom());
            @(posedge clk);
            #1;
        end
        idle(10);

        issue(1, 48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b0, 1'b1, 1'b0);
        do_reset(2);
        idle(2);
        issue(1, 48'hFFFF_FFFF_FFFF, 48'd0, 1'b0, 1'b1, 1'b0);
        issue(1, 48'd5, 48'd7, 1'b1, 1'b0, 1'b0);
        idle(10);

        n = 0;
        while ((q0.size() + q1.size()) > 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(q0.size() + q1.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mbledhesi_sekuencial.md
# mbledhesi_sekuencial

Parametrised multi-cycle adder/subtractor for the 24-bit CPU datapath. It generalises the fixed 48-bit two-stage adder to any WIDTH, processing one CHUNK-bit slice per clock with a registered carry. A START/READY/DONE handshake lets the control unit trade latency for adder area on wide operations such as multiply accumulate and 48-bit address arithmetic. Add and subtract share one carry chain.

## Interface
- WIDTH, 48: operand and result width; must be a multiple of CHUNK.
- CHUNK, 24: bits added per clock; NCH = WIDTH/CHUNK slices.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; accepted only on an edge where READY=1.
- SUB  in  1  0: A+B+CIN; 1: A-B-CIN, with CIN acting as borrow-in.
- A  in  WIDTH  operand A, sampled at accept.
- B  in  WIDTH  operand B, sampled at accept.
- CIN  in  1  carry-in or borrow-in, sampled at accept.
- READY  out  1  high when a START would be accepted.
- DONE  out  1  one-cycle pulse; result valid.
- SHUMA  out  WIDTH  result.
- CARRYOUT  out  1  carry out of the MSB (for SUB, 1 means no borrow).
- OVF  out  1  signed overflow; present only with MBLEDHESI_OVF_EN.

## Operation
- Three states: IDLE, RUN and FUND.
- IDLE
  - READY=1.
  - START=1 moves the block to RUN.
  - On that edge it latches A and B_eff = SUB ? ~B : B, sets carry c = CIN ^ SUB, and clears slice counter k to 0.
- RUN
  - READY=0.
  - Each edge computes {c, part[k*CHUNK +: CHUNK]} = A slice + B_eff slice + c, then increments k.
  - After the slice k = NCH-1 edge, the block copies part into SHUMA, copies c into CARRYOUT, and moves to FUND.
  - START is ignored in RUN. Operands are not re-sampled.
- FUND
  - DONE=1 and READY=1 for exactly one cycle.
  - START=1 in this cycle is accepted and goes straight to RUN. Otherwise the block returns to IDLE.
- SHUMA, CARRYOUT and OVF hold their last result until the next completion. They do not change during RUN.
- Arithmetic is modulo 2^WIDTH. The k counter is $clog2(NCH) bits wide, minimum 1.
- Reset asserted at any time, including mid-RUN: state goes to IDLE and the partial result is discarded. No DONE is produced.
- Reset values:
  - READY=1, DONE=0, SHUMA=0, CARRYOUT=0, OVF=0.
  - Internal: k=0, c=0, part=0.

## Timing
- Accept edge E0. Slices are computed on edges E1..E_NCH. DONE is high in the cycle after E_NCH.
- Latency from accept to DONE is NCH edges. With the defaults that is 2 cycles.
- Back-to-back throughput is one result per NCH+1 cycles, achieved when START is held high through FUND.
- NCH=1 is legal: RUN lasts one edge.
- Critical path is one CHUNK-bit ripple plus the carry register.

## Configuration
- MBLEDHESI_OVF_EN defined:
  - OVF port exists.
  - At the final slice, OVF = (A[MSB] == B_eff[MSB]) && (sum[MSB] != A[MSB]).
  - OVF is registered with SHUMA, holds with it, and resets to 0.
- MBLEDHESI_OVF_EN undefined:
  - OVF port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold RST_N=0 with random inputs -> READY=1, DONE=0, SHUMA=0, CARRYOUT=0. START while in reset is ignored.
- Cross-slice carry: A=48'h0000_00FF_FFFF, B=1, CIN=0, SUB=0 -> DONE 2 cycles after accept, SHUMA=48'h0000_0100_0000, CARRYOUT=0.
- Full ripple: A=48'hFFFF_FFFF_FFFF, B=0, CIN=1 -> SHUMA=0, CARRYOUT=1. With SUB=1, A=5, B=7, CIN=0 -> SHUMA=48'hFFFF_FFFF_FFFE, CARRYOUT=0.
- Overflow (macro on): A=48'h7FFF_FFFF_FFFF, B=1, add -> SHUMA=48'h8000_0000_0000, OVF=1. Then A=3, B=1, SUB=1 -> SHUMA=2, OVF=0, CARRYOUT=1.
- Handshake, WIDTH=48, CHUNK=8:
  - START held high -> DONE pulses every 7 cycles.
  - START pulses during RUN are ignored, and SHUMA stays stable until E_NCH.
- Mid-op reset: assert RST_N=0 during the second slice of a 6-slice op -> no DONE, SHUMA=0. A following op completes correctly.
